valid_data_arbiter: RTL and testbench
=====================================

Name: valid_data_arbiter

Overview:
- Shares a single registered valid/data output stage (DATA_W-bit data, qualified by valid) between NUM_REQ requesters.
- Round-robin arbitration with a bounded burst allowance and a ready/valid handshake toward the consumer.
- Tracks accepted data words equal to MATCH_VALUE with a sticky flag and a saturating counter.
- Sits between stimulus/requester logic and the clocked datapath that consumes valid/data.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 3, payload width per requester.
- MAX_BURST, 2, max consecutive grants to one requester while another requester is waiting (>=1).
- MATCH_VALUE, 5, data value tracked by the match logic.
- CNT_W, 8, width of match_count.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester request; held with req_data until ack.
- req_data  in  NUM_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-hot combinational pulse; requester i's word is loaded this cycle.
- valid  out  1  output stage holds a word.
- data  out  DATA_W  output word; stable while valid && !ready.
- ready  in  1  consumer accepts the word when valid && ready.
- grant  out  NUM_REQ  one-hot owner of the current output word; 0 when !valid.
- match_seen  out  1  sticky; set when an accepted-into-stage word == MATCH_VALUE.
- match_count  out  CNT_W  count of loaded words == MATCH_VALUE; saturates at all-ones.

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: valid=0, data=0, grant=0, match_seen=0, match_count=0, ack=0 (ack also forced 0 while rst is high).
  - Internal state: last_owner=NUM_REQ-1, so requester 0 has first priority; burst_cnt=0.
  - Reset mid-transfer drops the held word; no ack is issued for it.
- Load condition: load = (|req) && (!valid || ready).
  - When load=1: select requester s; ack[s]=1 that cycle.
  - Next edge: data<=req_data[s], valid<=1, grant<=onehot(s).
- Drain: if valid && ready && !(|req), then at the next edge valid<=0, grant<=0. data holds its last value.
- Stall: if valid && !ready, the output stage and all state hold, ack=0, and no arbitration occurs.
- Selection rule:
  - Keep the owner: if req[last_owner]=1 and either burst_cnt < MAX_BURST-1 or no other req is set, then s=last_owner.
  - Otherwise: s = first set req scanning last_owner+1, +2, ... modulo NUM_REQ, wrapping.
- Burst counter (updated on load only):
  - s==last_owner: burst_cnt <= burst_cnt+1, saturating at MAX_BURST-1.
  - Else: burst_cnt <= 0, last_owner <= s.
- Sole requester: a lone requester is granted every load cycle indefinitely; the burst limit only applies when another requester is waiting.
- Throughput: one word per cycle while ready=1 and requests are pending. Latency from ack to valid is 1 cycle.
- Match tracking:
  - Evaluated on loaded data (req_data[s] at load).
  - Sets match_seen and increments match_count the same edge the word enters the stage.
  - match_count saturates at 2^CNT_W-1.
- Simultaneous events: ready and a new req in the same cycle reload the stage back-to-back, with no bubble and no valid drop.
- State machine (explicit encoding): EMPTY (valid=0), FULL (valid=1).
  - EMPTY -> FULL on load.
  - FULL -> FULL on ready && load, or on !ready.
  - FULL -> EMPTY on ready && !load.
  - Any state -> EMPTY on rst.

Test Plan:
- Reset then idle: rst high 2 cycles, no req -> valid=0, data=0, grant=0, match_count=0. Assert rst mid-FULL -> valid=0 the next cycle.
- Single requester stream: req=4'b0010, req_data[1]=3, ready=1 for 5 cycles -> ack[1]=1 every cycle, valid=1 from cycle 2, data=3, grant=4'b0010, no bubbles.
- Round-robin with burst: MAX_BURST=2, req=4'b1111 constant, ready=1 -> grant sequence 0,0,1,1,2,2,3,3,0,0 (wrap-around checked).
- Backpressure: valid=1, data=3, ready=0 for 4 cycles while req=4'b0100 -> data/grant frozen, ack=0. Raise ready -> ack[2]=1 that cycle, new word next cycle.
- Match coverage: requester 3 sends 5, then 0, then 5 -> match_seen=1 after the first load, match_count=2. With CNT_W=2, send 5 four times -> match_count stays at 3.
- Drain: a single word, then req=0, ready=1 -> valid falls exactly 1 cycle after acceptance and grant=0. Re-request the next cycle -> the stage refills with a 1-cycle gap.

Source files
------------

// File: rtl/valid_data_arbiter.sv
// Round-robin arbiter with burst allowance feeding one registered valid/data stage; tracks MATCH_VALUE words.
// Latency: ack to valid/data is 1 cycle; one word per cycle while ready is high.
// Backpressure: valid && !ready freezes the stage and arbitration state, and ack stays 0.
module valid_data_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 3,
    parameter int MAX_BURST   = 2,
    parameter int MATCH_VALUE = 5,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      valid,
    output logic [DATA_W-1:0]         data,
    input  logic                      ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      match_seen,
    output logic [CNT_W-1:0]          match_count
);

    localparam int OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [OWN_W-1:0]   LAST_IDX   = OWN_W'(NUM_REQ - 1);
    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST - 1);
    localparam logic [DATA_W-1:0]  MATCH_WORD = DATA_W'(MATCH_VALUE);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [OWN_W-1:0]     last_owner;
    logic [BURST_W-1:0]   burst_cnt;
    logic                 has_owner;
    logic                 load;
    logic                 others_waiting;
    logic                 keep_owner;
    logic [OWN_W-1:0]     sel;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_match;

    // Stage can take a new word when empty or when the held word leaves this cycle.
    assign load = !rst && (|req) && ((state == EMPTY) || ready);

    assign others_waiting = |(req & ~(NUM_REQ'(1) << last_owner));

    // Nobody owns the stage straight out of reset, so the scan from last_owner+1
    // gives requester 0 first priority instead of re-granting NUM_REQ-1.
    assign keep_owner = has_owner && req[last_owner] &&
                        ((burst_cnt < BURST_MAX) || !others_waiting);

    always_comb begin : rr_scan
        logic             found;
        logic [OWN_W-1:0] idx;
        sel   = last_owner;
        found = 1'b0;
        idx   = '0;
        if (!keep_owner) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = OWN_W'((int'(last_owner) + k) % NUM_REQ);
                if (!found && req[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end
    end

    assign sel_onehot = NUM_REQ'(1) << sel;
    assign sel_data   = req_data[int'(sel)*DATA_W +: DATA_W];
    assign sel_match  = (sel_data == MATCH_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (ready && !load) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        valid = (state == FULL);
        ack   = load ? sel_onehot : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data        <= '0;
            grant       <= '0;
            last_owner  <= LAST_IDX;
            burst_cnt   <= '0;
            has_owner   <= 1'b0;
            match_seen  <= 1'b0;
            match_count <= '0;
        end else if (load) begin
            data      <= sel_data;
            grant     <= sel_onehot;
            has_owner <= 1'b1;
            if (has_owner && (sel == last_owner)) begin
                if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                burst_cnt  <= '0;
                last_owner <= sel;
            end
            if (sel_match) begin
                match_seen <= 1'b1;
                if (match_count != CNT_MAX) begin
                    match_count <= match_count + 1'b1;
                end
            end
        end else if ((state == FULL) && ready) begin
            // Drain: data keeps its last value, only ownership is released.
            grant <= '0;
        end
    end

    a_ack_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
    a_grant_tracks_valid : assert property (@(posedge clk) disable iff (rst)
        (valid ? $onehot(grant) : (grant == '0)));

endmodule

// File: tb/tb_valid_data_arbiter.sv
// Directed and randomized bench for valid_data_arbiter against a queue-free behavioural model.
module tb_valid_data_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 3;
    localparam int MAX_BURST   = 2;
    localparam int MATCH_VALUE = 5;
    localparam int CNT_W       = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      valid;
    logic [DATA_W-1:0]         data;
    logic                      ready;
    logic [NUM_REQ-1:0]        grant;
    logic                      match_seen;
    logic [CNT_W-1:0]          match_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit                 m_valid;
    int                 m_data;
    int                 m_owner;
    int                 m_last;
    int                 m_burst;
    bit                 m_started;
    bit                 m_seen;
    int                 m_count;
    logic [NUM_REQ-1:0] exp_ack;
    logic [NUM_REQ-1:0] ack_obs;
    bit   [NUM_REQ-1:0] pend;

    valid_data_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .MAX_BURST   (MAX_BURST),
        .MATCH_VALUE (MATCH_VALUE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .valid       (valid),
        .data        (data),
        .ready       (ready),
        .grant       (grant),
        .match_seen  (match_seen),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = 0;
        m_owner   = -1;
        m_last    = NUM_REQ - 1;
        m_burst   = 0;
        m_started = 1'b0;
        m_seen    = 1'b0;
        m_count   = 0;
    endtask

    // Round robin with burst: stay with the owner while allowed, else next requester after it.
    function automatic int pick();
        int others = 0;
        for (int i = 0; i < NUM_REQ; i++)
            if (i != m_last && req[i]) others++;
        if (m_started && req[m_last] && (m_burst < MAX_BURST - 1 || others == 0))
            return m_last;
        for (int k = 1; k <= NUM_REQ; k++)
            if (req[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic set_word(input int i, input int v);
        req_data[i*DATA_W +: DATA_W] = DATA_W'(v);
    endtask

    // One clock: check ack mid-cycle, advance the model on the edge, check the stage after it.
    task automatic do_cycle();
        int s;
        int w;
        bit ld;
        @(negedge clk);
        s  = -1;
        w  = 0;
        ld = 1'b0;
        if (!rst && req != '0 && (!m_valid || ready)) begin
            ld = 1'b1;
            s  = pick();
            w  = int'(req_data[s*DATA_W +: DATA_W]);
        end
        exp_ack = ld ? (NUM_REQ'(1) << s) : '0;
        ack_obs = ack;
        check("ack", ack, exp_ack);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (ld) begin
            m_valid = 1'b1;
            m_data  = w;
            m_owner = s;
            if (m_started && s == m_last) begin
                m_burst = (m_burst + 1 > MAX_BURST - 1) ? MAX_BURST - 1 : m_burst + 1;
            end else begin
                m_burst = 0;
                m_last  = s;
            end
            m_started = 1'b1;
            if (w == MATCH_VALUE) begin
                m_seen = 1'b1;
                if (m_count < (1 << CNT_W) - 1) m_count++;
            end
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
            m_owner = -1;
        end
        #1;
        check("valid", valid, m_valid);
        check("data", data, m_data);
        check("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
        check("match_seen", match_seen, m_seen);
        check("match_count", match_count, m_count);
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        req = '0;
        do_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int rr [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int mv [6]  = '{5, 0, 5, 5, 5, 5};
        int mc [6]  = '{1, 1, 2, 3, 3, 3};

        model_reset();
        exp_ack  = '0;
        ack_obs  = '0;
        pend     = '0;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        ready    = 1'b0;

        // Reset then idle
        do_cycle();
        do_cycle();
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_grant", grant, 0);
        check("rst_count", match_count, 0);
        rst = 1'b0;
        do_cycle();
        check("idle_valid", valid, 0);

        // Reset while FULL drops the word and suppresses ack
        req = 4'b0001;
        set_word(0, 6);
        do_cycle();
        check("prefill_valid", valid, 1);
        req = '0;
        do_cycle();
        rst = 1'b1;
        req = 4'b0010;
        set_word(1, 2);
        do_cycle();
        check("midrst_ack", ack_obs, 0);
        check("midrst_valid", valid, 0);
        rst = 1'b0;

        // Single requester stream
        req   = 4'b0010;
        set_word(1, 3);
        ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            do_cycle();
            check("single_ack", ack_obs, 4'b0010);
            check("single_valid", valid, 1);
            check("single_data", data, 3);
            check("single_grant", grant, 4'b0010);
        end

        // Round robin with burst of two
        reset_cycle();
        ready = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_word(i, i + 1);
        for (int i = 0; i < 10; i++) begin
            do_cycle();
            check("rr_grant", grant, 1 << rr[i]);
            check("rr_data", data, rr[i] + 1);
        end

        // Backpressure
        reset_cycle();
        ready = 1'b1;
        req   = 4'b0100;
        set_word(2, 3);
        do_cycle();
        set_word(2, 6);
        ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            do_cycle();
            check("bp_ack", ack_obs, 0);
            check("bp_data", data, 3);
            check("bp_grant", grant, 4'b0100);
        end
        ready = 1'b1;
        do_cycle();
        check("bp_release_ack", ack_obs, 4'b0100);
        check("bp_release_data", data, 6);
        req = '0;
        do_cycle();

        // Match tracking with saturation at 3
        reset_cycle();
        ready = 1'b1;
        req   = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            set_word(3, mv[i]);
            do_cycle();
            check("match_seen_dir", match_seen, 1);
            check("match_count_dir", match_count, mc[i]);
        end

        // Drain and refill with one bubble
        reset_cycle();
        ready = 1'b1;
        req   = 4'b0001;
        set_word(0, 2);
        do_cycle();
        check("drain_fill", valid, 1);
        req = '0;
        do_cycle();
        check("drain_valid", valid, 0);
        check("drain_grant", grant, 0);
        check("drain_data_hold", data, 2);
        req = 4'b0001;
        set_word(0, 4);
        do_cycle();
        check("refill_ack", ack_obs, 4'b0001);
        check("refill_valid", valid, 1);
        check("refill_data", data, 4);
        req = '0;
        do_cycle();

        // Randomized traffic: requests held until acked, random ready and rare reset
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    set_word(i, int'($urandom_range(0, (1 << DATA_W) - 1)));
                end
            end
            req   = pend;
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 99) == 0);
            do_cycle();
            pend = pend & ~exp_ack;
        end
        rst = 1'b0;
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
